lift_call_scheduler: RTL

Upstream controller for the four-floor lift: latches floor-call buttons, picks a travel direction with a SCAN (keep-going-while-work-remains) policy, and drives the `stop_go`/`up_down` inputs of the floor state machine. It reads the machine's `output_floor` back as `cur_floor`. It also times door-open dwell and inter-floor travel so the floor machine advances exactly one floor per issued step.

---
 rtl/lift_call_scheduler.sv | 104 ++++++++++
 1 files changed

// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler for a four-floor lift: latches calls, chooses direction,
// issues single-floor step pulses and times travel and door-open dwell.
module lift_call_scheduler #(
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] call_req,
  input  logic [1:0] cur_floor,
  output logic       stop_go,
  output logic       up_down,
  output logic       door_open,
  output logic [3:0] pending,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_TRAVEL = 2'd2,
    S_DOOR   = 2'd3
  } state_t;

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_t     r_state;
  logic       r_dir;
  logic [3:0] r_pending;
  logic [7:0] r_cnt;

  logic [3:0] w_here_mask;
  logic [3:0] w_above_mask;
  logic [3:0] w_below_mask;
  logic       w_here;
  logic       w_above;
  logic       w_below;
  logic       w_clear_now;
  logic [3:0] w_clr;

  assign w_here_mask  = 4'b0001 << cur_floor;
  assign w_above_mask = 4'b1110 << cur_floor;
  assign w_below_mask = ~(w_above_mask | w_here_mask);

  assign w_here  = |(r_pending & w_here_mask);
  assign w_above = |(r_pending & w_above_mask);
  assign w_below = |(r_pending & w_below_mask);

  // The current floor's call is cleared on the cycle the door decision is
  // taken and for the whole dwell, so presses at an open door are absorbed.
  assign w_clear_now = ((r_state == S_IDLE) && w_here) || (r_state == S_DOOR);
  assign w_clr       = w_clear_now ? w_here_mask : 4'b0000;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b1;
      r_pending <= 4'b0000;
      r_cnt     <= 8'd0;
    end else begin
      r_pending <= (r_pending | call_req) & ~w_clr;
      case (r_state)
        S_IDLE: begin
          // Keep the current direction while work remains ahead of the car.
          if (w_here) begin
            r_state <= S_DOOR;
            r_cnt   <= DOOR_LOAD;
          end else if (r_dir && w_above) begin
            r_state <= S_STEP;
          end else if (!r_dir && w_below) begin
            r_state <= S_STEP;
          end else if (w_above) begin
            r_dir   <= 1'b1;
            r_state <= S_STEP;
          end else if (w_below) begin
            r_dir   <= 1'b0;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_state <= S_TRAVEL;
          r_cnt   <= TRAVEL_LOAD;
        end
        S_TRAVEL: begin
          if (r_cnt == 8'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_DOOR: begin
          if (r_cnt == 8'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stop_go     = (r_state != S_STEP);
  assign door_open   = (r_state == S_DOOR);
  assign up_down     = r_dir;
  assign pending     = r_pending;
  assign o_dbg_state = r_state;

endmodule
